// File: rtl/pci_bridge_wb_slave_model.sv
// WISHBONE B3 slave memory responder for the PCI bridge master port: wait states, CTI/BTE
// bursts, out-of-window ERR. Optional RTY injection is enabled by PCI_BRIDGE_WB_SLAVE_RETRY_EN.
module pci_bridge_wb_slave_model #(
  parameter int unsigned   DW         = 32,
  parameter int unsigned   AW         = 32,
  parameter int unsigned   DEPTH_LOG2 = 10,
  parameter logic [AW-1:0] BASE_ADDR  = '0,
  parameter int unsigned   WS_W       = 4
) (
  input  logic              clk,
  input  logic              RST_N_I,
  input  logic [AW-1:0]     ADR_I,
  input  logic [DW-1:0]     DAT_I,
  output logic [DW-1:0]     DAT_O,
  input  logic [DW/8-1:0]   SEL_I,
  input  logic              CYC_I,
  input  logic              STB_I,
  input  logic              WE_I,
  input  logic [2:0]        CTI_I,
  input  logic [1:0]        BTE_I,
  output logic              ACK_O,
  output logic              RTY_O,
  output logic              ERR_O,
  input  logic [WS_W-1:0]   wait_states,
  input  logic [7:0]        retry_every,
  output logic [15:0]       ack_count
);

  localparam int unsigned BpwLog2 = (DW == 64) ? 3 : 2;
  localparam int unsigned WinLog2 = DEPTH_LOG2 + BpwLog2;
  localparam int unsigned Depth   = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] IdxOne = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {StIdle, StWait, StBeat, StBurst} state_e;

  state_e                state_q, state_d;
  logic [WS_W-1:0]       ws_cnt_q, ws_cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  in_win_q, in_win_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DW-1:0]         dat_q, dat_d;
  logic [15:0]           ack_cnt_q;
  logic                  rty_q;

  logic [DW-1:0]         mem [Depth];

  logic                  req;
  logic                  adr_in_win;
  logic [DEPTH_LOG2-1:0] adr_idx;
  logic [DEPTH_LOG2-1:0] nidx;
  logic                  burst_ovf;
  logic                  term_q;
  logic                  beat_done;
  logic                  mem_we;
  logic                  unused_bits;

  // Wrap modes only advance the low index bits; the rest of the index stays put.
  function automatic logic [DEPTH_LOG2-1:0] next_index(input logic [DEPTH_LOG2-1:0] idx,
                                                       input logic [1:0] bte);
    logic [DEPTH_LOG2-1:0] mask;
    unique case (bte)
      2'b01:   mask = DEPTH_LOG2'(4'h3);
      2'b10:   mask = DEPTH_LOG2'(4'h7);
      2'b11:   mask = DEPTH_LOG2'(4'hf);
      default: mask = '1;
    endcase
    return (idx & ~mask) | ((idx + IdxOne) & mask);
  endfunction

  assign req        = CYC_I & STB_I;
  assign adr_in_win = (ADR_I[AW-1:WinLog2] == BASE_ADDR[AW-1:WinLog2]);
  assign adr_idx    = ADR_I[WinLog2-1:BpwLog2];
  assign nidx       = next_index(idx_q, BTE_I);
  assign burst_ovf  = (BTE_I == 2'b00) && (idx_q == '1);
  assign term_q     = ack_q | err_q | rty_q;
  assign beat_done  = ack_q & STB_I;
  assign mem_we     = beat_done & WE_I;

`ifdef PCI_BRIDGE_WB_SLAVE_RETRY_EN
  logic       rty_d;
  logic       rty_flag_q, rty_flag_d;
  logic [7:0] rty_cnt_q, rty_cnt_d;
  assign unused_bits = ^ADR_I[BpwLog2-1:0];
`else
  assign rty_q       = 1'b0;
  assign unused_bits = ^{ADR_I[BpwLog2-1:0], retry_every};
`endif

  always_comb begin
    state_d  = state_q;
    ws_cnt_d = ws_cnt_q;
    idx_d    = idx_q;
    in_win_d = in_win_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dat_d    = dat_q;
`ifdef PCI_BRIDGE_WB_SLAVE_RETRY_EN
    rty_d      = 1'b0;
    rty_flag_d = rty_flag_q;
    rty_cnt_d  = (retry_every == 8'd0) ? 8'd0 : rty_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req) begin
          ws_cnt_d = wait_states;
          idx_d    = adr_idx;
          in_win_d = adr_in_win;
          state_d  = (wait_states == '0) ? StBeat : StWait;
`ifdef PCI_BRIDGE_WB_SLAVE_RETRY_EN
          if (retry_every != 8'd0 && rty_cnt_q + 8'd1 == retry_every) begin
            rty_flag_d = 1'b1;
            rty_cnt_d  = 8'd0;
          end else begin
            rty_flag_d = 1'b0;
            rty_cnt_d  = (retry_every == 8'd0) ? 8'd0 : rty_cnt_q + 8'd1;
          end
`endif
        end
      end
      StWait: begin
        if (!CYC_I) begin
          state_d = StIdle;
        end else begin
          ws_cnt_d = ws_cnt_q - 1'b1;
          if (ws_cnt_q == WS_W'(1)) state_d = StBeat;
        end
      end
      StBeat: begin
        if (term_q) begin
          // Termination edge: a continuing burst issues its next beat right away.
          state_d = StIdle;
          if (ack_q && req && CTI_I == 3'b010) begin
            if (burst_ovf) begin
              err_d    = 1'b1;
              in_win_d = 1'b0;
              state_d  = StBeat;
            end else begin
              idx_d   = nidx;
              ack_d   = 1'b1;
              dat_d   = mem[nidx];
              state_d = StBurst;
            end
          end
        end else if (!CYC_I) begin
          state_d = StIdle;
        end else if (!in_win_q) begin
          err_d = 1'b1;
`ifdef PCI_BRIDGE_WB_SLAVE_RETRY_EN
        end else if (rty_flag_q) begin
          rty_d = 1'b1;
`endif
        end else begin
          ack_d = 1'b1;
          dat_d = mem[idx_q];
        end
      end
      StBurst: begin
        if (!CYC_I) begin
          state_d = StIdle;
        end else if (beat_done) begin
          if (CTI_I == 3'b111) begin
            state_d = StIdle;
          end else if (burst_ovf) begin
            err_d    = 1'b1;
            in_win_d = 1'b0;
            state_d  = StBeat;
          end else begin
            idx_d = nidx;
            ack_d = 1'b1;
            dat_d = mem[nidx];
          end
        end else if (STB_I) begin
          ack_d = 1'b1;
          dat_d = mem[idx_q];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q   <= StIdle;
      ws_cnt_q  <= '0;
      idx_q     <= '0;
      in_win_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      ack_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ws_cnt_q <= ws_cnt_d;
      idx_q    <= idx_d;
      in_win_q <= in_win_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
      if (beat_done) ack_cnt_q <= ack_cnt_q + 16'd1;
    end
  end

`ifdef PCI_BRIDGE_WB_SLAVE_RETRY_EN
  always_ff @(posedge clk or negedge RST_N_I) begin
    if (!RST_N_I) begin
      rty_q      <= 1'b0;
      rty_flag_q <= 1'b0;
      rty_cnt_q  <= 8'd0;
    end else begin
      rty_q      <= rty_d;
      rty_flag_q <= rty_flag_d;
      rty_cnt_q  <= rty_cnt_d;
    end
  end
`endif

  // Storage is deliberately not reset; ack_q is cleared asynchronously so reset blocks writes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (SEL_I[b]) mem[idx_q][8*b +: 8] <= DAT_I[8*b +: 8];
      end
    end
  end

  assign DAT_O     = dat_q;
  assign ACK_O     = ack_q;
  assign ERR_O     = err_q;
  assign RTY_O     = rty_q;
  assign ack_count = ack_cnt_q;

endmodule

// File: tb/tb_pci_bridge_wb_slave_model.sv
// Directed self-checking bench for pci_bridge_wb_slave_model (default 32-bit, 1024-word build).
module tb_pci_bridge_wb_slave_model;

  logic        clk = 1'b0;
  logic        RST_N_I;
  logic [31:0] ADR_I, DAT_I, DAT_O;
  logic [3:0]  SEL_I;
  logic        CYC_I, STB_I, WE_I;
  logic [2:0]  CTI_I;
  logic [1:0]  BTE_I;
  logic        ACK_O, RTY_O, ERR_O;
  logic [3:0]  wait_states;
  logic [7:0]  retry_every;
  logic [15:0] ack_count;

  int checks = 0;
  int errors = 0;

  int          lat;
  logic [2:0]  term;
  logic [31:0] rdat;
  logic        after;
  logic [2:0]  exp_term;

  always #5 clk = ~clk;

  pci_bridge_wb_slave_model dut (
    .clk         (clk),
    .RST_N_I     (RST_N_I),
    .ADR_I       (ADR_I),
    .DAT_I       (DAT_I),
    .DAT_O       (DAT_O),
    .SEL_I       (SEL_I),
    .CYC_I       (CYC_I),
    .STB_I       (STB_I),
    .WE_I        (WE_I),
    .CTI_I       (CTI_I),
    .BTE_I       (BTE_I),
    .ACK_O       (ACK_O),
    .RTY_O       (RTY_O),
    .ERR_O       (ERR_O),
    .wait_states (wait_states),
    .retry_every (retry_every),
    .ack_count   (ack_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; CTI_I = 3'b000; BTE_I = 2'b00;
  endtask

  // Classic single transfer; term = {ACK,RTY,ERR}, after = any termination one cycle later.
  task automatic classic(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [3:0] sel, output int lat_o, output logic [2:0] term_o,
                         output logic [31:0] rdat_o, output logic after_o);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = wdat; SEL_I = sel;
    CTI_I = 3'b000; BTE_I = 2'b00;
    lat_o = 0; term_o = 3'b000; rdat_o = '0;
    @(posedge clk); #1;
    while (term_o == 3'b000 && lat_o < 20) begin
      @(posedge clk); #1;
      lat_o++;
      if (ACK_O | RTY_O | ERR_O) begin
        term_o = {ACK_O, RTY_O, ERR_O};
        rdat_o = DAT_O;
      end
    end
    @(posedge clk); #1;
    after_o = ACK_O | RTY_O | ERR_O;
    idle_bus();
  endtask

  initial begin
    RST_N_I = 1'b0; ADR_I = '0; DAT_I = '0; SEL_I = '0;
    idle_bus();
    wait_states = 4'd0; retry_every = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ACK_O}, 32'd0);
    check("rst_rty", {31'd0, RTY_O}, 32'd0);
    check("rst_err", {31'd0, ERR_O}, 32'd0);
    check("rst_dat", DAT_O, 32'd0);
    check("rst_cnt", {16'd0, ack_count}, 32'd0);
    RST_N_I = 1'b1;
    @(posedge clk); #1;

    // Two wait states: write then read back word 1.
    wait_states = 4'd2;
    classic(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, lat, term, rdat, after);
    check("ws2_wr_term", {29'd0, term}, 32'd4);
    check("ws2_wr_lat", lat, 32'd3);
    classic(1'b0, 32'h4, 32'h0, 4'hF, lat, term, rdat, after);
    check("ws2_rd_term", {29'd0, term}, 32'd4);
    check("ws2_rd_lat", lat, 32'd3);
    check("ws2_rd_dat", rdat, 32'hDEADBEEF);
    check("ws2_one_cycle", {31'd0, after}, 32'd0);
    check("ws2_cnt", {16'd0, ack_count}, 32'd2);

    // Byte-lane merge.
    wait_states = 4'd0;
    classic(1'b1, 32'h8, 32'hFFFFFFFF, 4'hF, lat, term, rdat, after);
    classic(1'b1, 32'h8, 32'h11223344, 4'b0101, lat, term, rdat, after);
    classic(1'b0, 32'h8, 32'h0, 4'hF, lat, term, rdat, after);
    check("sel_lat", lat, 32'd1);
    check("sel_dat", rdat, 32'hFF22FF44);
    check("sel_cnt", {16'd0, ack_count}, 32'd5);

    // Preload words 0..3 with A0..A3.
    for (int i = 0; i < 4; i++) begin
      classic(1'b1, 32'(4 * i), 32'hA0 + 32'(i), 4'hF, lat, term, rdat, after);
    end
    check("pre_cnt", {16'd0, ack_count}, 32'd9);

    // Wrap4 read from word 2: beats 2,3,0,1 on consecutive cycles.
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 32'h8; CTI_I = 3'b010; BTE_I = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("w4_b0_ack", {31'd0, ACK_O}, 32'd1);
    check("w4_b0_dat", DAT_O, 32'hA2);
    ADR_I = 32'hC;
    @(posedge clk); #1;
    check("w4_b1_ack", {31'd0, ACK_O}, 32'd1);
    check("w4_b1_dat", DAT_O, 32'hA3);
    ADR_I = 32'h0;
    @(posedge clk); #1;
    check("w4_b2_ack", {31'd0, ACK_O}, 32'd1);
    check("w4_b2_dat", DAT_O, 32'hA0);
    ADR_I = 32'h4;
    @(posedge clk); #1;
    check("w4_b3_ack", {31'd0, ACK_O}, 32'd1);
    check("w4_b3_dat", DAT_O, 32'hA1);
    CTI_I = 3'b111;
    @(posedge clk); #1;
    check("w4_end_ack", {31'd0, ACK_O}, 32'd0);
    check("w4_cnt", {16'd0, ack_count}, 32'd13);
    idle_bus();

    // Just past the window: ERR, no write, count unchanged.
    classic(1'b1, 32'h1000, 32'h55, 4'hF, lat, term, rdat, after);
    check("err_term", {29'd0, term}, 32'd1);
    check("err_lat", lat, 32'd1);
    check("err_one_cycle", {31'd0, after}, 32'd0);
    check("err_cnt", {16'd0, ack_count}, 32'd13);
    classic(1'b0, 32'h0, 32'h0, 4'hF, lat, term, rdat, after);
    check("err_mem_kept", rdat, 32'hA0);

    // Linear burst from the last word: one ACK then a single ERR.
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 32'hFFC; CTI_I = 3'b010; BTE_I = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ovf_ack", {31'd0, ACK_O}, 32'd1);
    @(posedge clk); #1;
    check("ovf_err", {30'd0, ACK_O, ERR_O}, 32'd1);
    @(posedge clk); #1;
    check("ovf_done", {30'd0, ACK_O, ERR_O}, 32'd0);
    idle_bus();
    check("ovf_cnt", {16'd0, ack_count}, 32'd15);

    // Retry injection every third request.
    retry_every = 8'd3;
    for (int i = 0; i < 6; i++) begin
      classic(1'b0, 32'h0, 32'h0, 4'hF, lat, term, rdat, after);
`ifdef PCI_BRIDGE_WB_SLAVE_RETRY_EN
      exp_term = (i == 2 || i == 5) ? 3'b010 : 3'b100;
`else
      exp_term = 3'b100;
`endif
      check($sformatf("retry_req%0d", i + 1), {29'd0, term}, {29'd0, exp_term});
    end
`ifdef PCI_BRIDGE_WB_SLAVE_RETRY_EN
    check("retry_cnt", {16'd0, ack_count}, 32'd19);
`else
    check("retry_cnt", {16'd0, ack_count}, 32'd21);
`endif
    retry_every = 8'd0;

    // Reset in the middle of an 8-beat linear burst.
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 32'h0; CTI_I = 3'b010; BTE_I = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mrst_b0_dat", DAT_O, 32'hA0);
    @(posedge clk); #1;
    check("mrst_b1_ack", {31'd0, ACK_O}, 32'd1);
    check("mrst_b1_dat", DAT_O, 32'hA1);
    #2 RST_N_I = 1'b0;
    #1;
    check("mrst_ack_low", {31'd0, ACK_O}, 32'd0);
    check("mrst_dat", DAT_O, 32'd0);
    check("mrst_cnt", {16'd0, ack_count}, 32'd0);
    idle_bus();
    @(posedge clk); #1;
    RST_N_I = 1'b1;
    @(posedge clk); #1;
    classic(1'b0, 32'h4, 32'h0, 4'hF, lat, term, rdat, after);
    check("post_term", {29'd0, term}, 32'd4);
    check("post_lat", lat, 32'd1);
    check("post_dat", rdat, 32'hA1);
    check("post_cnt", {16'd0, ack_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
